// File: rtl/forward_sb.sv
// forward_sb: operand forwarding scoreboard over STAGES x LANES in-flight producers.
// Optional FORWARD_SB_STATS_EN adds saturating stat_fwd/stat_stall counters.
module forward_sb #(
  parameter int LANES  = 2,
  parameter int STAGES = 2,
  parameter int XLEN   = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [LANES-1:0]              iss_valid,
  input  logic [LANES*10-1:0]           iss_src,
  input  logic [LANES*5-1:0]            iss_rd,
  input  logic [LANES-1:0]              iss_wen,
  input  logic [LANES*2*XLEN-1:0]       rf_data,
  input  logic [STAGES*LANES*XLEN-1:0]  stg_data,
  input  logic [STAGES*LANES-1:0]       stg_rdy,
  input  logic                          hold_in,
  input  logic                          flush,
  output logic [LANES*2*XLEN-1:0]       src_data,
`ifdef FORWARD_SB_STATS_EN
  output logic [31:0]                   stat_fwd,
  output logic [31:0]                   stat_stall,
`endif
  output logic                          stall_out
);
  logic [LANES-1:0] t_valid [STAGES];
  logic [LANES-1:0] t_wen [STAGES];
  logic [4:0]       t_rd [STAGES][LANES];
  logic [4:0]       src;
  logic             hit, hit_rdy, stall_raw;
  logic [XLEN-1:0]  hit_data;
  logic [3:0]       fwd_cnt;
  // Scan oldest row first and lanes ascending so the last match is the youngest producer.
  always_comb begin
    src_data  = rf_data;
    stall_raw = 1'b0;
    fwd_cnt   = '0;
    src       = '0;
    hit       = 1'b0;
    hit_rdy   = 1'b0;
    hit_data  = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int o = 0; o < 2; o++) begin
        src      = iss_src[(l*2+o)*5+:5];
        hit      = 1'b0;
        hit_rdy  = 1'b0;
        hit_data = '0;
        for (int s = STAGES-1; s >= 0; s--)
          for (int k = 0; k < LANES; k++)
            if (t_valid[s][k] && t_wen[s][k] && t_rd[s][k] == src) begin
              hit      = 1'b1;
              hit_rdy  = stg_rdy[s*LANES+k];
              hit_data = stg_data[(s*LANES+k)*XLEN+:XLEN];
            end
        if (src != 5'd0 && hit) begin
          if (hit_rdy) begin
            src_data[(l*2+o)*XLEN+:XLEN] = hit_data;
            fwd_cnt = fwd_cnt + {3'd0, iss_valid[l]};
          end else if (iss_valid[l])
            stall_raw = 1'b1;
        end
        for (int i = 0; i < l; i++)
          if (iss_valid[l] && iss_valid[i] && iss_wen[i] && src != 5'd0 && iss_rd[i*5+:5] == src)
            stall_raw = 1'b1;
      end
    end
    stall_out = stall_raw | hold_in;
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int s = 0; s < STAGES; s++) t_valid[s] <= '0;
    end else if (!hold_in) begin
      t_valid[0] <= stall_out ? '0 : iss_valid;
      for (int l = 0; l < LANES; l++) begin
        t_wen[0][l] <= iss_wen[l] && (iss_rd[l*5+:5] != 5'd0);
        t_rd[0][l]  <= iss_rd[l*5+:5];
      end
      for (int s = 1; s < STAGES; s++) begin
        t_valid[s] <= t_valid[s-1];
        t_wen[s]   <= t_wen[s-1];
        t_rd[s]    <= t_rd[s-1];
      end
    end
  end
`ifdef FORWARD_SB_STATS_EN
  logic [32:0] fwd_sum;
  assign fwd_sum = {1'b0, stat_fwd} + {29'd0, fwd_cnt};
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fwd   <= '0;
      stat_stall <= '0;
    end else begin
      if (!stall_out) stat_fwd <= fwd_sum[32] ? 32'hFFFF_FFFF : fwd_sum[31:0];
      if (stall_out && !hold_in && stat_stall != 32'hFFFF_FFFF) stat_stall <= stat_stall + 32'd1;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^fwd_cnt;
`endif
endmodule

// File: tb/tb_forward_sb.sv
// tb_forward_sb: directed checks of forward_sb forwarding, stalls, hold, flush and reset.
module tb_forward_sb;
  logic         clk = 1'b0;
  logic         rst, hold_in, flush;
  logic [1:0]   iss_valid, iss_wen;
  logic [19:0]  iss_src;
  logic [9:0]   iss_rd;
  logic [127:0] rf_data, stg_data, src_data;
  logic [3:0]   stg_rdy;
  logic         stall_out;
  int           vecs = 0, errs = 0;
`ifdef FORWARD_SB_STATS_EN
  logic [31:0]  stat_fwd, stat_stall;
`endif

  forward_sb dut (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_src(iss_src), .iss_rd(iss_rd),
    .iss_wen(iss_wen), .rf_data(rf_data), .stg_data(stg_data), .stg_rdy(stg_rdy),
    .hold_in(hold_in), .flush(flush), .src_data(src_data),
`ifdef FORWARD_SB_STATS_EN
    .stat_fwd(stat_fwd), .stat_stall(stat_stall),
`endif
    .stall_out(stall_out)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [4:0] rj0, rk0, rj1, rk1, rd0, rd1,
                       input logic [1:0] wen);
    iss_valid = v;
    iss_src   = {rk1, rj1, rk0, rj0};
    iss_rd    = {rd1, rd0};
    iss_wen   = wen;
    #1;
  endtask

  task automatic clr;
    drive(2'b00, 0, 0, 0, 0, 0, 0, 2'b00);
    stg_rdy = '0;
    stg_data = '0;
    flush = 1'b1;
    tick;
    flush = 1'b0;
  endtask

  task automatic test_reset;
    drive(2'b01, 5, 6, 0, 0, 0, 0, 2'b00);
    vecs++; if (stall_out !== 1'b0) begin errs++; $display("FAIL reset_stall got %0b want 0", stall_out); end
    vecs++; if (src_data !== rf_data) begin errs++; $display("FAIL reset_src got %h want %h", src_data, rf_data); end
  endtask

  task automatic test_forward;
    clr;
    drive(2'b01, 0, 0, 0, 0, 5, 0, 2'b01);
    tick;
    stg_rdy = 4'b0001;
    stg_data[31:0] = 32'h1234;
    drive(2'b10, 0, 0, 5, 0, 0, 0, 2'b00);
    vecs++; if (src_data[95:64] !== 32'h1234) begin errs++; $display("FAIL fwd_rj got %h want 00001234", src_data[95:64]); end
    vecs++; if (src_data[127:96] !== 32'hF000_0003) begin errs++; $display("FAIL fwd_r0 got %h want f0000003", src_data[127:96]); end
    vecs++; if (stall_out !== 1'b0) begin errs++; $display("FAIL fwd_stall got %0b want 0", stall_out); end
  endtask

  task automatic test_priority;
    clr;
    drive(2'b10, 0, 0, 0, 0, 0, 7, 2'b10);
    tick;
    drive(2'b01, 0, 0, 0, 0, 7, 0, 2'b01);
    tick;
    stg_rdy = 4'b1111;
    stg_data = {32'h0000_B1B1, 32'h0000_B0B0, 32'h0000_A1A1, 32'h0000_A0A0};
    drive(2'b01, 0, 7, 0, 0, 0, 0, 2'b00);
    vecs++; if (src_data[63:32] !== 32'h0000_A0A0) begin errs++; $display("FAIL prio_row got %h want 0000a0a0", src_data[63:32]); end
    clr;
    drive(2'b11, 0, 0, 0, 0, 7, 7, 2'b11);
    tick;
    stg_rdy = 4'b1111;
    stg_data = {32'h0000_D1D1, 32'h0000_D0D0, 32'h0000_C1C1, 32'h0000_C0C0};
    drive(2'b01, 7, 0, 0, 0, 0, 0, 2'b00);
    vecs++; if (src_data[31:0] !== 32'h0000_C1C1) begin errs++; $display("FAIL prio_lane got %h want 0000c1c1", src_data[31:0]); end
  endtask

  task automatic test_load_stall;
    clr;
    drive(2'b01, 0, 0, 0, 0, 3, 0, 2'b01);
    tick;
    drive(2'b01, 3, 0, 0, 0, 3, 0, 2'b01);
    vecs++; if (stall_out !== 1'b1) begin errs++; $display("FAIL load_stall got %0b want 1", stall_out); end
    tick;
    stg_rdy = 4'b0100;
    stg_data[95:64] = 32'h33;
    #1;
    vecs++; if (stall_out !== 1'b0) begin errs++; $display("FAIL load_release got %0b want 0", stall_out); end
    vecs++; if (src_data[31:0] !== 32'h33) begin errs++; $display("FAIL load_fwd got %h want 00000033", src_data[31:0]); end
  endtask

  task automatic test_intra;
    clr;
    drive(2'b11, 0, 0, 9, 0, 9, 0, 2'b01);
    vecs++; if (stall_out !== 1'b1) begin errs++; $display("FAIL intra_stall got %0b want 1", stall_out); end
    drive(2'b11, 9, 0, 0, 0, 0, 9, 2'b10);
    vecs++; if (stall_out !== 1'b0) begin errs++; $display("FAIL intra_younger got %0b want 0", stall_out); end
    drive(2'b11, 0, 0, 9, 0, 9, 0, 2'b00);
    vecs++; if (stall_out !== 1'b0) begin errs++; $display("FAIL intra_nowen got %0b want 0", stall_out); end
    drive(2'b01, 0, 0, 0, 0, 0, 0, 2'b01);
    tick;
    stg_rdy = 4'b1111;
    stg_data = {4{32'hDEAD_BEEF}};
    drive(2'b11, 0, 0, 0, 0, 0, 0, 2'b11);
    vecs++; if (stall_out !== 1'b0) begin errs++; $display("FAIL r0_stall got %0b want 0", stall_out); end
    vecs++; if (src_data !== rf_data) begin errs++; $display("FAIL r0_src got %h want %h", src_data, rf_data); end
  endtask

  task automatic test_hold_flush;
    clr;
    drive(2'b01, 0, 0, 0, 0, 4, 0, 2'b01);
    tick;
    hold_in = 1'b1;
    drive(2'b00, 0, 0, 0, 0, 0, 0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      vecs++; if (stall_out !== 1'b1) begin errs++; $display("FAIL hold_stall%0d got %0b want 1", i, stall_out); end
      if (i < 2) tick;
    end
    stg_rdy = 4'b0001;
    stg_data[31:0] = 32'h44;
    drive(2'b01, 4, 0, 0, 0, 0, 0, 2'b00);
    vecs++; if (src_data[31:0] !== 32'h44) begin errs++; $display("FAIL hold_keep got %h want 00000044", src_data[31:0]); end
    tick;
    flush = 1'b1;
    #1;
    vecs++; if (src_data[31:0] !== 32'h44) begin errs++; $display("FAIL flush_src got %h want 00000044", src_data[31:0]); end
    tick;
    flush = 1'b0;
    hold_in = 1'b0;
    stg_rdy = 4'b1111;
    #1;
    vecs++; if (src_data[31:0] !== 32'hF000_0000) begin errs++; $display("FAIL flush_clear got %h want f0000000", src_data[31:0]); end
    vecs++; if (stall_out !== 1'b0) begin errs++; $display("FAIL flush_stall got %0b want 0", stall_out); end
    clr;
    drive(2'b01, 0, 0, 0, 0, 6, 0, 2'b01);
    tick;
    drive(2'b01, 6, 0, 0, 0, 0, 0, 2'b00);
    vecs++; if (stall_out !== 1'b1) begin errs++; $display("FAIL rst_pre got %0b want 1", stall_out); end
    rst = 1'b1;
    hold_in = 1'b1;
    flush = 1'b1;
    tick;
    rst = 1'b0;
    hold_in = 1'b0;
    flush = 1'b0;
    #1;
    vecs++; if (stall_out !== 1'b0) begin errs++; $display("FAIL rst_mid got %0b want 0", stall_out); end
    vecs++; if (src_data !== rf_data) begin errs++; $display("FAIL rst_src got %h want %h", src_data, rf_data); end
  endtask

`ifdef FORWARD_SB_STATS_EN
  task automatic test_stats;
    drive(2'b00, 0, 0, 0, 0, 0, 0, 2'b00);
    stg_rdy = '0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    drive(2'b11, 0, 0, 0, 0, 5, 6, 2'b11);
    tick;
    stg_rdy = 4'b1111;
    drive(2'b11, 5, 6, 5, 6, 0, 0, 2'b00);
    tick;
    drive(2'b11, 0, 0, 8, 0, 8, 0, 2'b01);
    tick;
    tick;
    drive(2'b00, 0, 0, 0, 0, 0, 0, 2'b00);
    vecs++; if (stat_fwd !== 32'd4) begin errs++; $display("FAIL stat_fwd got %0d want 4", stat_fwd); end
    vecs++; if (stat_stall !== 32'd2) begin errs++; $display("FAIL stat_stall got %0d want 2", stat_stall); end
    dut.stat_fwd = 32'hFFFF_FFFF;
    dut.stat_stall = 32'hFFFF_FFFF;
    drive(2'b01, 0, 0, 0, 0, 5, 0, 2'b01);
    tick;
    drive(2'b11, 5, 5, 0, 0, 0, 0, 2'b00);
    tick;
    drive(2'b11, 0, 0, 8, 0, 8, 0, 2'b01);
    tick;
    vecs++; if (stat_fwd !== 32'hFFFF_FFFF) begin errs++; $display("FAIL stat_fwd_sat got %h want ffffffff", stat_fwd); end
    vecs++; if (stat_stall !== 32'hFFFF_FFFF) begin errs++; $display("FAIL stat_stall_sat got %h want ffffffff", stat_stall); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    hold_in = 1'b0;
    flush = 1'b0;
    stg_rdy = '0;
    stg_data = '0;
    rf_data = {32'hF000_0003, 32'hF000_0002, 32'hF000_0001, 32'hF000_0000};
    drive(2'b00, 0, 0, 0, 0, 0, 0, 2'b00);
    repeat (3) tick;
    rst = 1'b0;
    #1;
    test_reset;
    test_forward;
    test_priority;
    test_load_stall;
    test_intra;
    test_hold_flush;
`ifdef FORWARD_SB_STATS_EN
    test_stats;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
